// File: rtl/shared_port_mux_if.sv
// Bus bundle between four granted requesters, the shared output port and its
// status outputs.
//   gnt_n     one-hot grant from the upstream arbiter
//   vld_n     requester n presents a beat; data_n is its payload
//   rdy_n     beat from requester n accepted this cycle
//   out_rdy   downstream sink accepts out_data this cycle
//   out_vld   out_data/out_src hold a valid registered beat
//   burst_done/burst_len  one-cycle end-of-grant pulse and beat count
//   err_multi sticky flag, more than one grant bit seen
// modport master: requester/sink side, modport slave: the mux.
interface shared_port_mux_if #(
    parameter int DW = 8
);
    logic          gnt_0, gnt_1, gnt_2, gnt_3;
    logic          vld_0, vld_1, vld_2, vld_3;
    logic [DW-1:0] data_0, data_1, data_2, data_3;
    logic          rdy_0, rdy_1, rdy_2, rdy_3;
    logic          out_rdy;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          burst_done;
    logic [7:0]    burst_len;
    logic          err_multi;

    modport master (
        output gnt_0, gnt_1, gnt_2, gnt_3,
        output vld_0, vld_1, vld_2, vld_3,
        output data_0, data_1, data_2, data_3,
        output out_rdy,
        input  rdy_0, rdy_1, rdy_2, rdy_3,
        input  out_vld, out_data, out_src, burst_done, burst_len, err_multi
    );

    modport slave (
        input  gnt_0, gnt_1, gnt_2, gnt_3,
        input  vld_0, vld_1, vld_2, vld_3,
        input  data_0, data_1, data_2, data_3,
        input  out_rdy,
        output rdy_0, rdy_1, rdy_2, rdy_3,
        output out_vld, out_data, out_src, burst_done, burst_len, err_multi
    );
endinterface

// File: rtl/shared_port_mux.sv
// Shared output port multiplexer. Follows the one-hot grant of an upstream
// 4-way arbiter, forwards the granted requester's beats into a single
// registered output stage (one beat per cycle when the sink keeps up), counts
// the beats of each grant and reports the count when the grant ends.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    shared_port_mux_if.slave: gnt_n/vld_n/data_n in, rdy_n out,
//          out_rdy in, out_vld/out_data/out_src/burst_done/burst_len/err_multi out
module shared_port_mux #(
    parameter int DW = 8
) (
    input logic             clk,
    input logic             reset,
    shared_port_mux_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StXfer  = 3'b010,
        StDrain = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_src_q, out_src_d;
    logic          burst_done_q, burst_done_d;
    logic [7:0]    burst_len_q, burst_len_d;
    logic          err_multi_q, err_multi_d;

    logic [3:0]    gnt, vld, src_mask, rdy;
    logic [DW-1:0] data_arr [4];
    logic [2:0]    gnt_cnt;
    logic          gnt_multi, gnt_single;
    logic [1:0]    gnt_idx;
    logic          xfer_exit, capture;

    assign gnt = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
    assign vld = {bus.vld_3, bus.vld_2, bus.vld_1, bus.vld_0};

    always_comb begin
        data_arr[0] = bus.data_0;
        data_arr[1] = bus.data_1;
        data_arr[2] = bus.data_2;
        data_arr[3] = bus.data_3;
    end

    assign gnt_cnt    = 3'(gnt[0]) + 3'(gnt[1]) + 3'(gnt[2]) + 3'(gnt[3]);
    assign gnt_multi  = (gnt_cnt > 3'd1);
    assign gnt_single = (gnt_cnt == 3'd1);

    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) gnt_idx = 2'(i);
        end
    end

    assign src_mask = 4'b0001 << src_q;

    // Grant lost or another grant bit raised: the burst ends this cycle and
    // the beat presented now is refused.
    assign xfer_exit = !gnt[src_q] || (|(gnt & ~src_mask));

    // Accept when the output stage is empty or is being emptied this cycle.
    assign capture = (state_q == StXfer) && !reset && !xfer_exit && vld[src_q] &&
                     (!out_vld_q || bus.out_rdy);

    assign rdy = capture ? src_mask : 4'b0000;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        beat_cnt_d   = beat_cnt_q;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        burst_done_d = 1'b0;
        burst_len_d  = burst_len_q;
        err_multi_d  = err_multi_q | gnt_multi;

        if (capture) begin
            out_vld_d  = 1'b1;
            out_data_d = data_arr[src_q];
            out_src_d  = src_q;
            beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
        end else if (out_vld_q && bus.out_rdy) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (gnt_single) begin
                    state_d    = StXfer;
                    src_d      = gnt_idx;
                    beat_cnt_d = 8'd0;
                end
            end
            StXfer: begin
                if (xfer_exit) begin
                    state_d      = StDrain;
                    burst_done_d = 1'b1;
                    burst_len_d  = beat_cnt_d;
                end
            end
            StDrain: begin
                if (!out_vld_q || bus.out_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            src_q        <= 2'd0;
            beat_cnt_q   <= 8'd0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 2'd0;
            burst_done_q <= 1'b0;
            burst_len_q  <= 8'd0;
            err_multi_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            beat_cnt_q   <= beat_cnt_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            burst_done_q <= burst_done_d;
            burst_len_q  <= burst_len_d;
            err_multi_q  <= err_multi_d;
        end
    end

    assign bus.rdy_0      = rdy[0];
    assign bus.rdy_1      = rdy[1];
    assign bus.rdy_2      = rdy[2];
    assign bus.rdy_3      = rdy[3];
    assign bus.out_vld    = out_vld_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.burst_done = burst_done_q;
    assign bus.burst_len  = burst_len_q;
    assign bus.err_multi  = err_multi_q;

endmodule

// File: tb/tb_shared_port_mux.sv
// Randomised and directed bench for shared_port_mux with a behavioural
// reference model and an in-order delivery scoreboard.
module tb_shared_port_mux;
    localparam int DW = 8;
    localparam int M_IDLE  = 0;
    localparam int M_XFER  = 1;
    localparam int M_DRAIN = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]    g_in, v_in;
    logic [DW-1:0] d_in [4];
    logic          ordy;
    logic [3:0]    dut_rdy;

    shared_port_mux_if #(.DW(DW)) bus ();

    shared_port_mux #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.gnt_0   = g_in[0];
    assign bus.gnt_1   = g_in[1];
    assign bus.gnt_2   = g_in[2];
    assign bus.gnt_3   = g_in[3];
    assign bus.vld_0   = v_in[0];
    assign bus.vld_1   = v_in[1];
    assign bus.vld_2   = v_in[2];
    assign bus.vld_3   = v_in[3];
    assign bus.data_0  = d_in[0];
    assign bus.data_1  = d_in[1];
    assign bus.data_2  = d_in[2];
    assign bus.data_3  = d_in[3];
    assign bus.out_rdy = ordy;
    assign dut_rdy     = {bus.rdy_3, bus.rdy_2, bus.rdy_1, bus.rdy_0};

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    int cyc      = 0;
    logic [3:0] last_rdy;

    // Reference model: mode, granted source, beat count, output stage.
    int            m_mode = M_IDLE;
    logic [1:0]    m_src  = 2'd0;
    int            m_cnt  = 0;
    bit            m_ov   = 1'b0;
    logic [DW-1:0] m_od   = '0;
    logic [1:0]    m_os   = 2'd0;
    bit            m_done = 1'b0;
    int            m_len  = 0;
    bit            m_err  = 1'b0;

    logic [DW+1:0] exp_q [$];
    logic [DW-1:0] obs_data [$];
    logic [1:0]    obs_src [$];
    int            obs_cyc [$];
    int            len_log [$];

    logic [3:0] er;
    int         ones;
    bit         leave, acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (checking) begin
            ones  = $countones(g_in);
            er    = 4'b0000;
            leave = 1'b0;
            if (m_mode == M_XFER) begin
                leave = !g_in[m_src] || (ones > 1);
                if (!reset && !leave && v_in[m_src] && (!m_ov || ordy)) er[m_src] = 1'b1;
            end

            check("rdy", 32'(dut_rdy), 32'(er));
            check("out_vld", 32'(bus.out_vld), 32'(m_ov));
            check("out_data", 32'(bus.out_data), 32'(m_od));
            check("out_src", 32'(bus.out_src), 32'(m_os));
            check("burst_done", 32'(bus.burst_done), 32'(m_done));
            if (m_done) check("burst_len", 32'(bus.burst_len), 32'(m_len));
            check("err_multi", 32'(bus.err_multi), 32'(m_err));

            if (!reset && bus.out_vld && ordy) begin
                obs_data.push_back(bus.out_data);
                obs_src.push_back(bus.out_src);
                obs_cyc.push_back(cyc);
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("sb_beat", 32'({bus.out_src, bus.out_data}),
                                            32'(exp_q.pop_front()));
            end
            if (bus.burst_done) len_log.push_back(int'(bus.burst_len));

            acc = (er != 4'b0000);
            if (reset) begin
                m_mode = M_IDLE; m_src = 2'd0; m_cnt = 0; m_ov = 1'b0; m_od = '0;
                m_os = 2'd0; m_done = 1'b0; m_len = 0; m_err = 1'b0;
                exp_q.delete();
            end else begin
                if (ones > 1) m_err = 1'b1;
                m_done = 1'b0;
                if (acc) exp_q.push_back({m_src, d_in[m_src]});
                case (m_mode)
                    M_IDLE: begin
                        if (ones == 1) begin
                            m_mode = M_XFER;
                            for (int i = 0; i < 4; i++) if (g_in[i]) m_src = 2'(i);
                            m_cnt = 0;
                        end
                    end
                    M_XFER: begin
                        if (acc && m_cnt < 255) m_cnt++;
                        if (leave) begin
                            m_done = 1'b1;
                            m_len  = m_cnt;
                            m_mode = M_DRAIN;
                        end
                    end
                    default: if (!m_ov || ordy) m_mode = M_IDLE;
                endcase
                if (acc) begin
                    m_ov = 1'b1;
                    m_od = d_in[m_src];
                    m_os = m_src;
                end else if (m_ov && ordy) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        last_rdy = dut_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        g_in = 4'b0000;
        v_in = 4'b0000;
        for (int i = 0; i < 4; i++) d_in[i] = '0;
        ordy = 1'b1;
    endtask

    task automatic clear_logs();
        obs_data.delete();
        obs_src.delete();
        obs_cyc.delete();
        len_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        int r;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        checking = 1'b1;
        tick();
        reset = 1'b0;

        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_src", 32'(bus.out_src), 32'd0);
        check("rst_burst_done", 32'(bus.burst_done), 32'd0);
        check("rst_burst_len", 32'(bus.burst_len), 32'd0);
        check("rst_err_multi", 32'(bus.err_multi), 32'd0);

        // Three-beat burst from requester 1.
        clear_logs();
        g_in = 4'b0010; v_in = 4'b0010; d_in[1] = 8'h11;
        tick();
        tick(); d_in[1] = 8'h12;
        tick(); d_in[1] = 8'h13;
        tick();
        idle_inputs();
        repeat (4) tick();
        check("b3_count", 32'(obs_data.size()), 32'd3);
        check("b3_beat0", 32'(obs_data[0]), 32'h11);
        check("b3_beat1", 32'(obs_data[1]), 32'h12);
        check("b3_beat2", 32'(obs_data[2]), 32'h13);
        check("b3_src", 32'(obs_src[2]), 32'd1);
        check("b3_back_to_back", 32'(obs_cyc[2] - obs_cyc[0]), 32'd2);
        check("b3_done_count", 32'(len_log.size()), 32'd1);
        check("b3_len", 32'(len_log[0]), 32'd3);

        // Sink stall for four cycles.
        clear_logs();
        g_in = 4'b0001; v_in = 4'b0001; d_in[0] = 8'hA0; ordy = 1'b0;
        tick();
        tick();
        if (last_rdy[0]) d_in[0] = d_in[0] + 8'd1;
        for (int i = 0; i < 4; i++) begin
            check("stall_rdy0", 32'(bus.rdy_0), 32'd0);
            check("stall_data", 32'(bus.out_data), 32'hA0);
            tick();
            if (last_rdy[0]) d_in[0] = d_in[0] + 8'd1;
        end
        ordy = 1'b1;
        repeat (3) begin
            tick();
            if (last_rdy[0]) d_in[0] = d_in[0] + 8'd1;
        end
        idle_inputs();
        repeat (4) tick();
        check("stall_count", 32'(obs_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("stall_beat", 32'(obs_data[i]), 32'(8'hA0 + i));
        check("stall_len", 32'(len_log[0]), 32'd4);

        // Empty grant.
        clear_logs();
        g_in = 4'b0100;
        repeat (3) tick();
        g_in = 4'b0000;
        repeat (4) tick();
        check("empty_beats", 32'(obs_data.size()), 32'd0);
        check("empty_done_count", 32'(len_log.size()), 32'd1);
        check("empty_len", 32'(len_log[0]), 32'd0);

        // 300-beat burst, saturating count.
        clear_logs();
        g_in = 4'b1000; v_in = 4'b1000; d_in[3] = 8'h00;
        tick();
        accepted = 0;
        for (int guard = 0; guard < 2000 && accepted < 300; guard++) begin
            ordy = ($urandom_range(0, 3) != 0);
            tick();
            if (last_rdy[3]) begin
                accepted++;
                d_in[3] = d_in[3] + 8'd1;
            end
        end
        check("long_accepted", 32'(accepted), 32'd300);
        idle_inputs();
        repeat (4) tick();
        check("long_delivered", 32'(obs_data.size()), 32'd300);
        check("long_last", 32'(obs_data[299]), 32'h2B);
        check("long_len", 32'(len_log[0]), 32'd255);

        // Two grants at once.
        clear_logs();
        g_in = 4'b1001; v_in = 4'b1111;
        repeat (3) tick();
        check("multi_err", 32'(bus.err_multi), 32'd1);
        idle_inputs();
        repeat (3) tick();
        check("multi_sticky", 32'(bus.err_multi), 32'd1);
        check("multi_no_beats", 32'(obs_data.size()), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("multi_cleared", 32'(bus.err_multi), 32'd0);

        // Reset with a pending output beat.
        clear_logs();
        g_in = 4'b0010; v_in = 4'b0010; d_in[1] = 8'h55; ordy = 1'b0;
        tick();
        tick();
        check("rstmid_pending", 32'(bus.out_vld), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_vld", 32'(bus.out_vld), 32'd0);
        idle_inputs();
        repeat (3) tick();
        check("rstmid_no_done", 32'(len_log.size()), 32'd0);

        // Randomised traffic.
        idle_inputs();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3)      g_in = 4'b0000;
                else if (r < 9) g_in = 4'b0001 << $urandom_range(0, 3);
                else            g_in = 4'($urandom);
            end
            v_in = 4'($urandom);
            for (int i = 0; i < 4; i++) d_in[i] = DW'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
